turbo_enc: RTL

TURBO_ENC -- requirements
Module: turbo_enc

---
 rtl/turbo_enc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/turbo_enc.sv
// -----------------------------------------------------------------------------
// turbo_enc
//   Rate-1/3 parallel-concatenated (turbo) encoder for a 5-bit info word.
//   Two identical 4-state RSC encoders run in parallel. Encoder 1 sees the
//   natural bit order, encoder 2 sees the interleaved order d0,d4,d2,d1,d3.
//   Each encoder is terminated to state 00 with two tail steps. The 21 code
//   bits (7 systematic, 7 parity1, 7 parity2) are mapped to 4-bit
//   two's-complement soft values (+AMP / -AMP). They are then sent as four
//   bit-planes, LSB plane first.
//
// Parameters
//   AMP      soft magnitude per code bit (1..7)
//
// Ports
//   clk_p_i  clock, rising edge
//   reset_i  synchronous active-high reset
//   start_i  encode request, sampled together with data_i (ignored when busy)
//   data_i   info word, data_i[4] = d0 (first in time), data_i[0] = d4
//   busy_o   high while the FSM is not IDLE
//   valid_o  high during the four bit-plane output cycles
//   data_o   bit-plane: [20:14] sys, [13:7] parity1, [6:0] parity2;
//            position i of a field sits at bit 6-i; zero when valid_o = 0
//   done_o   one-cycle pulse together with the last bit-plane
// -----------------------------------------------------------------------------
module turbo_enc #(
  parameter int AMP = 3
) (
  input  logic        clk_p_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [4:0]  data_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [20:0] data_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Soft values for a code bit of 1 and of 0.
  localparam logic [3:0] L_POS = 4'(AMP);
  localparam logic [3:0] L_NEG = 4'(-AMP);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [6:0]  r_sys;
  logic        r_valid;
  logic        r_done;
  logic [20:0] r_data_o;

  logic        w_accept;
  logic        w_tail;
  logic [4:0]  w_ilv;
  logic [9:0]  w_src;
  logic        w_sys_bit;
  logic [6:0]  w_par1;
  logic [6:0]  w_par2;
  logic [20:0] w_code;
  logic [20:0] w_plane;

  // A new block is accepted only from IDLE; anything else is dropped.
  assign w_accept = (r_state == IDLE) && start_i;

  // Steps 5 and 6 are termination steps driving the encoders back to 00.
  assign w_tail = (r_cnt >= 3'd5);

  // Interleaved order d0,d4,d2,d1,d3, presented MSB first like data_i.
  assign w_ilv = {data_i[4], data_i[0], data_i[2], data_i[3], data_i[1]};
  assign w_src = {w_ilv, data_i};

  // ---------------------------------------------------------------------------
  // Two RSC encoders. Each holds its own input shift register; the next info
  // bit is always the MSB. Parity bits are shifted in at the LSB so that
  // step 0 ends up at bit 6 after seven steps.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_enc
      logic       r_s1;
      logic       r_s2;
      logic [4:0] r_sh;
      logic [6:0] r_par;
      logic       w_u;
      logic       w_a;

      // During the tail, u = s1^s2 makes a = 0, forcing the state to 00.
      assign w_u = w_tail ? (r_s1 ^ r_s2) : r_sh[4];
      assign w_a = w_u ^ r_s1 ^ r_s2;

      always_ff @(posedge clk_p_i) begin
        if (reset_i) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_sh  <= '0;
          r_par <= '0;
        end else if (w_accept) begin
          r_s1  <= 1'b0;
          r_s2  <= 1'b0;
          r_sh  <= w_src[gi*5 +: 5];
          r_par <= '0;
        end else if (r_state == ENC) begin
          r_s1  <= w_a;
          r_s2  <= r_s1;
          r_sh  <= {r_sh[3:0], 1'b0};
          r_par <= {r_par[5:0], w_a ^ r_s2};
        end
      end
    end
  endgenerate

  // Only encoder 1's input (including its tail) is transmitted as systematic.
  assign w_sys_bit = g_enc[0].w_u;
  assign w_par1    = g_enc[0].r_par;
  assign w_par2    = g_enc[1].r_par;
  assign w_code    = {r_sys, w_par1, w_par2};

  // Bit-plane selection: in SEND, r_cnt is the plane index (0 = LSB).
  generate
    for (gi = 0; gi < 21; gi++) begin : g_plane
      assign w_plane[gi] = w_code[gi] ? L_POS[r_cnt[1:0]] : L_NEG[r_cnt[1:0]];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = ENC;
        end
      end
      ENC: begin
        if (r_cnt == 3'd6) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (r_cnt == 3'd3) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, step/plane counter and registered outputs. Planes are
  // registered, so plane k appears one edge after the SEND cycle that
  // selected it; the last plane is therefore visible in the first IDLE cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_p_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_sys    <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_data_o <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ENC: begin
          r_cnt    <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
          r_sys    <= {r_sys[5:0], w_sys_bit};
          r_valid  <= 1'b0;
          r_done   <= 1'b0;
          r_data_o <= '0;
        end
        SEND: begin
          r_cnt    <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
          r_valid  <= 1'b1;
          r_done   <= (r_cnt == 3'd3);
          r_data_o <= w_plane;
        end
        default: begin
          r_cnt    <= 3'd0;
          r_valid  <= 1'b0;
          r_done   <= 1'b0;
          r_data_o <= '0;
          if (w_accept) begin
            r_sys <= '0;
          end
        end
      endcase
    end
  end

  assign busy_o  = (r_state != IDLE);
  assign valid_o = r_valid;
  assign done_o  = r_done;
  assign data_o  = r_data_o;

endmodule
